micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UADDR_W, 6, micro-address width; address 2**UADDR_W-1 (63) is the illegal/unmapped code.
REQ-002 Parameter WAIT_W, 4, width of the microinstruction wait field.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mapped_address  in  UADDR_W  dispatch micro-address from the opcode mapper.
REQ-007 instr_valid  in  1  mapped_address is valid this cycle.
REQ-008 instr_ready  out  1  sequencer accepts a dispatch this cycle.
REQ-009 ucode_seq  in  2  sequencing op of the microinstruction at upc: 00 NEXT, 01 JUMP, 10 END, 11 reserved.
REQ-010 ucode_target  in  UADDR_W  jump target of the microinstruction at upc.
REQ-011 ucode_wait  in  WAIT_W  extra hold cycles before the sequencing op (multi-cycle ops, e.g. MUL).
REQ-012 stall  in  1  downstream stall; freezes sequencer state.
REQ-013 trap_ack  in  1  trap handler acknowledge.
REQ-014 upc  out  UADDR_W  current micro-address to the combinational control store.
REQ-015 upc_valid  out  1  microinstruction at upc is issued this cycle.
REQ-016 illegal_trap  out  1  illegal-instruction trap pending.

Function
REQ-017 States IDLE, EXEC, WAIT, TRAP; the control store is combinational, so ucode_* reflect upc in the same cycle.
REQ-018 IDLE: instr_ready=1, upc_valid=0; on instr_valid, mapped_address!=63 -> upc<=mapped_address, EXEC; mapped_address==63 -> upc<=63, TRAP.
REQ-019 EXEC: upc_valid=1; stall=1 -> hold all state, counter and upc.
REQ-020 EXEC, no stall, ucode_wait!=0 -> load counter with ucode_wait, enter WAIT, upc held.
REQ-021 EXEC, no stall, ucode_wait==0 -> apply ucode_seq: NEXT upc<=upc+1; JUMP upc<=ucode_target; END -> IDLE; 11 -> upc<=63, TRAP.
REQ-022 WAIT: upc_valid=0, upc held; counter decrements by 1 per non-stalled cycle; on the cycle the counter is 1, apply ucode_seq per REQ-021 (no wait reload).
REQ-023 Stall in WAIT freezes the counter.
REQ-024 A NEXT or JUMP resulting in upc==63 enters TRAP instead of EXEC; no wrap from 63 to 0.
REQ-025 Back-to-back: instr_ready=1 in an EXEC/WAIT cycle that applies END without stall; simultaneous instr_valid dispatches per REQ-018 with no IDLE bubble.
REQ-026 instr_ready=0 in all other EXEC/WAIT cycles and in TRAP; instr_valid then has no effect.
REQ-027 TRAP: illegal_trap=1, upc=63, upc_valid=0; trap_ack -> IDLE next cycle; stall ignored in TRAP.
REQ-028 upc_valid, instr_ready, illegal_trap are decoded from state and current inputs only; upc is registered.

Reset
REQ-029 reset_n low -> state IDLE, upc=0, counter=0, upc_valid=0, illegal_trap=0, instr_ready=1 while in IDLE.
REQ-030 Reset mid-EXEC/WAIT/TRAP aborts the instruction; no partial sequencing op is applied after release.
REQ-031 First dispatch is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-032 Package micro_seq_pkg holds UADDR_W, WAIT_W, ILLEGAL_UADDR=63, seq-op encodings and the state enum.
REQ-033 Sub-module micro_wait_counter (load, decrement-enable, last flag) implements the WAIT counter.

Verification
REQ-034 Dispatch 14 (ADDI), control store 14:END -> upc=14, upc_valid=1 one cycle, then IDLE.
REQ-035 Dispatch 27 (MUL), 27:ucode_wait=3, seq=NEXT; 28:END -> upc_valid at 27 one cycle, 3 WAIT cycles with upc_valid=0, then upc=28, then IDLE.
REQ-036 Dispatch 63 -> illegal_trap=1, instr_ready=0 until trap_ack; IDLE on the following cycle.
REQ-037 Dispatch 1 (END) with instr_valid held high and mapped_address=2 -> upc 1 then 2 on consecutive cycles, no bubble.
REQ-038 Stall held 2 cycles in EXEC at upc 13, JUMP target 25 -> upc stays 13 for 3 cycles, then 25.
REQ-039 reset_n pulsed low during WAIT with counter=2 -> immediate IDLE, upc=0, no further upc_valid.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared widths, sequencing-op encodings and FSM state type for the micro-sequencer.
package micro_seq_pkg;

   localparam int unsigned UADDR_W = 6;
   localparam int unsigned WAIT_W  = 4;

   // Highest micro-address is reserved as the illegal/unmapped code
   localparam logic [UADDR_W-1:0] ILLEGAL_UADDR = UADDR_W'(63);

   typedef enum logic [1:0] {
      SEQ_NEXT = 2'b00,
      SEQ_JUMP = 2'b01,
      SEQ_END  = 2'b10,
      SEQ_RSVD = 2'b11
   } seq_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_WAIT = 2'b10,
      S_TRAP = 2'b11
   } state_e;

endpackage

// File: rtl/micro_wait_counter.sv
// Down-counter holding the remaining hold cycles of a multi-cycle microinstruction.
module micro_wait_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         last_c
);

   logic [W-1:0] count;

   // Load takes priority; decrement saturates at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   // Final hold cycle: sequencing op is applied on this cycle
   always_comb begin
      last_c = (count == W'(1));
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: dispatches mapped micro-addresses and walks the control store.
module micro_sequencer #(
   parameter int unsigned UADDR_W = micro_seq_pkg::UADDR_W,
   parameter int unsigned WAIT_W  = micro_seq_pkg::WAIT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [UADDR_W-1:0] mapped_address,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [1:0]         ucode_seq,
   input  logic [UADDR_W-1:0] ucode_target,
   input  logic [WAIT_W-1:0]  ucode_wait,
   input  logic               stall,
   input  logic               trap_ack,
   output logic [UADDR_W-1:0] upc,
   output logic               upc_valid,
   output logic               illegal_trap
);

   import micro_seq_pkg::*;

   localparam logic [UADDR_W-1:0] ILLEGAL = {UADDR_W{1'b1}};

   state_e             state_q;
   state_e             state_d;
   logic [UADDR_W-1:0] upc_d;
   logic               cnt_load;
   logic               cnt_dec;
   logic               cnt_last;
   logic               apply_seq;

   micro_wait_counter #(
      .W (WAIT_W)
   ) u_wait_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (cnt_load),
      .load_value (ucode_wait),
      .dec        (cnt_dec),
      .last_c     (cnt_last)
   );

   // State and micro-PC registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         upc     <= '0;
      end else begin
         state_q <= state_d;
         upc     <= upc_d;
      end
   end

   // Next-state, micro-PC update and decoded handshake/status outputs
   always_comb begin
      state_d      = state_q;
      upc_d        = upc;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      instr_ready  = 1'b0;
      upc_valid    = 1'b0;
      illegal_trap = 1'b0;
      apply_seq    = 1'b0;

      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
         end
         S_EXEC: begin
            upc_valid = 1'b1;
            if (!stall) begin
               if (ucode_wait != '0) begin
                  cnt_load = 1'b1;
                  state_d  = S_WAIT;
               end else begin
                  apply_seq = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (!stall) begin
               cnt_dec = 1'b1;
               if (cnt_last) begin
                  apply_seq = 1'b1;
               end
            end
         end
         S_TRAP: begin
            illegal_trap = 1'b1;
            if (trap_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Sequencing op; landing on the illegal address traps rather than wrapping
      if (apply_seq) begin
         case (seq_op_e'(ucode_seq))
            SEQ_NEXT: begin
               upc_d   = upc + UADDR_W'(1);
               state_d = (upc_d == ILLEGAL) ? S_TRAP : S_EXEC;
            end
            SEQ_JUMP: begin
               upc_d   = ucode_target;
               state_d = (upc_d == ILLEGAL) ? S_TRAP : S_EXEC;
            end
            SEQ_END: begin
               state_d     = S_IDLE;
               instr_ready = 1'b1;
            end
            default: begin
               upc_d   = ILLEGAL;
               state_d = S_TRAP;
            end
         endcase
      end

      // Dispatch from IDLE or back-to-back on an END cycle
      if (instr_ready && instr_valid) begin
         upc_d   = mapped_address;
         state_d = (mapped_address == ILLEGAL) ? S_TRAP : S_EXEC;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a behavioural control store and an expectation queue.
module tb_micro_sequencer;

   typedef struct packed {
      logic       uv;
      logic [5:0] upc;
      logic       rdy;
      logic       trap;
   } obs_t;

   logic       clk;
   logic       reset_n;
   logic [5:0] mapped_address;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] ucode_seq;
   logic [5:0] ucode_target;
   logic [3:0] ucode_wait;
   logic       stall;
   logic       trap_ack;
   logic [5:0] upc;
   logic       upc_valid;
   logic       illegal_trap;

   logic [1:0] cs_seq  [64];
   logic [5:0] cs_tgt  [64];
   logic [3:0] cs_wait [64];

   obs_t exp_q[$];
   int   checks;
   int   failures;

   micro_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mapped_address (mapped_address),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .ucode_seq      (ucode_seq),
      .ucode_target   (ucode_target),
      .ucode_wait     (ucode_wait),
      .stall          (stall),
      .trap_ack       (trap_ack),
      .upc            (upc),
      .upc_valid      (upc_valid),
      .illegal_trap   (illegal_trap)
   );

   // Combinational control store indexed by the current micro-PC
   assign ucode_seq    = cs_seq[upc];
   assign ucode_target = cs_tgt[upc];
   assign ucode_wait   = cs_wait[upc];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic exp_obs(input logic uv, input logic [5:0] pc, input logic rdy, input logic trap);
      obs_t e;
      e.uv   = uv;
      e.upc  = pc;
      e.rdy  = rdy;
      e.trap = trap;
      exp_q.push_back(e);
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle against the queue head
   task automatic cyc(input string tag, input logic iv, input logic [5:0] addr,
                      input logic stl, input logic ack);
      obs_t got;
      obs_t want;
      instr_valid    = iv;
      mapped_address = addr;
      stall          = stl;
      trap_ack       = ack;
      @(negedge clk);
      got.uv   = upc_valid;
      got.upc  = upc;
      got.rdy  = instr_ready;
      got.trap = illegal_trap;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s: no expectation queued", tag);
      end else begin
         want = exp_q.pop_front();
         assert (got === want) else begin
            failures++;
            $error("FAIL %s: got uv=%0b upc=%0d rdy=%0b trap=%0b, want uv=%0b upc=%0d rdy=%0b trap=%0b",
                   tag, got.uv, got.upc, got.rdy, got.trap, want.uv, want.upc, want.rdy, want.trap);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset_n        = 1'b0;
      instr_valid    = 1'b0;
      mapped_address = '0;
      stall          = 1'b0;
      trap_ack       = 1'b0;
      for (int i = 0; i < 64; i++) begin
         cs_seq[i]  = 2'b10;
         cs_tgt[i]  = '0;
         cs_wait[i] = '0;
      end
      cs_wait[27] = 4'd3; cs_seq[27] = 2'b00;
      cs_seq[13]  = 2'b01; cs_tgt[13] = 6'd25;
      cs_seq[62]  = 2'b00;
      cs_seq[40]  = 2'b11;
      cs_wait[30] = 4'd2;

      // Reset state; dispatch attempt during reset is ignored
      @(posedge clk); #1;
      exp_obs(0, 0, 1, 0); cyc("reset", 1, 6'd14, 0, 0);
      reset_n = 1'b1;

      // Single-cycle END instruction, dispatched on first edge after reset
      exp_obs(0, 0, 1, 0);  cyc("addi_disp", 1, 6'd14, 0, 0);
      exp_obs(1, 14, 1, 0); cyc("addi_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 14, 1, 0); cyc("addi_idle", 0, 6'd0, 0, 0);

      // Multi-cycle op: three hold cycles then NEXT
      exp_obs(0, 14, 1, 0); cyc("mul_disp", 1, 6'd27, 0, 0);
      exp_obs(1, 27, 0, 0); cyc("mul_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 27, 0, 0); cyc("mul_wait1", 1, 6'd5, 0, 0);
      exp_obs(0, 27, 0, 0); cyc("mul_wait2", 0, 6'd0, 0, 0);
      exp_obs(0, 27, 0, 0); cyc("mul_wait3", 0, 6'd0, 0, 0);
      exp_obs(1, 28, 1, 0); cyc("mul_next", 0, 6'd0, 0, 0);
      exp_obs(0, 28, 1, 0); cyc("mul_idle", 0, 6'd0, 0, 0);

      // Illegal dispatch: trap until acknowledged, stall and dispatch ignored
      exp_obs(0, 28, 1, 0); cyc("ill_disp", 1, 6'd63, 0, 0);
      exp_obs(0, 63, 0, 1); cyc("ill_trap", 1, 6'd5, 1, 0);
      exp_obs(0, 63, 0, 1); cyc("ill_ack", 0, 6'd0, 0, 1);
      exp_obs(0, 63, 1, 0); cyc("ill_idle", 0, 6'd0, 0, 0);

      // Back-to-back dispatch on an END cycle
      exp_obs(0, 63, 1, 0); cyc("b2b_disp1", 1, 6'd1, 0, 0);
      exp_obs(1, 1, 1, 0);  cyc("b2b_disp2", 1, 6'd2, 0, 0);
      exp_obs(1, 2, 1, 0);  cyc("b2b_exec2", 0, 6'd0, 0, 0);
      exp_obs(0, 2, 1, 0);  cyc("b2b_idle", 0, 6'd0, 0, 0);

      // Stall in EXEC holds upc, then JUMP
      exp_obs(0, 2, 1, 0);  cyc("stl_disp", 1, 6'd13, 0, 0);
      exp_obs(1, 13, 0, 0); cyc("stl_hold1", 1, 6'd4, 1, 0);
      exp_obs(1, 13, 0, 0); cyc("stl_hold2", 0, 6'd0, 1, 0);
      exp_obs(1, 13, 0, 0); cyc("stl_jump", 0, 6'd0, 0, 0);
      exp_obs(1, 25, 1, 0); cyc("stl_tgt", 0, 6'd0, 0, 0);
      exp_obs(0, 25, 1, 0); cyc("stl_idle", 0, 6'd0, 0, 0);

      // NEXT from 62 lands on the illegal address and traps
      exp_obs(0, 25, 1, 0); cyc("wrap_disp", 1, 6'd62, 0, 0);
      exp_obs(1, 62, 0, 0); cyc("wrap_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 63, 0, 1); cyc("wrap_trap", 1, 6'd3, 0, 0);
      exp_obs(0, 63, 0, 1); cyc("wrap_ack", 0, 6'd0, 0, 1);
      exp_obs(0, 63, 1, 0); cyc("wrap_idle", 0, 6'd0, 0, 0);

      // Reserved sequencing op traps
      exp_obs(0, 63, 1, 0); cyc("rsvd_disp", 1, 6'd40, 0, 0);
      exp_obs(1, 40, 0, 0); cyc("rsvd_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 63, 0, 1); cyc("rsvd_ack", 0, 6'd0, 0, 1);
      exp_obs(0, 63, 1, 0); cyc("rsvd_idle", 0, 6'd0, 0, 0);

      // Stall in WAIT freezes the counter; END from WAIT accepts a dispatch
      exp_obs(0, 63, 1, 0); cyc("ws_disp", 1, 6'd30, 0, 0);
      exp_obs(1, 30, 0, 0); cyc("ws_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 30, 0, 0); cyc("ws_stall1", 0, 6'd0, 1, 0);
      exp_obs(0, 30, 0, 0); cyc("ws_wait1", 1, 6'd5, 0, 0);
      exp_obs(0, 30, 0, 0); cyc("ws_stall2", 1, 6'd5, 1, 0);
      exp_obs(0, 30, 1, 0); cyc("ws_end", 1, 6'd31, 0, 0);
      exp_obs(1, 31, 1, 0); cyc("ws_next", 0, 6'd0, 0, 0);
      exp_obs(0, 31, 1, 0); cyc("ws_idle", 0, 6'd0, 0, 0);

      // Reset during WAIT with counter at 2 aborts the instruction
      exp_obs(0, 31, 1, 0); cyc("rw_disp", 1, 6'd27, 0, 0);
      exp_obs(1, 27, 0, 0); cyc("rw_exec", 0, 6'd0, 0, 0);
      exp_obs(0, 27, 0, 0); cyc("rw_wait", 0, 6'd0, 0, 0);
      reset_n = 1'b0;
      #1;
      exp_obs(0, 0, 1, 0);  cyc("rw_reset", 0, 6'd0, 0, 0);
      reset_n = 1'b1;
      exp_obs(0, 0, 1, 0);  cyc("rw_after1", 0, 6'd0, 0, 0);
      exp_obs(0, 0, 1, 0);  cyc("rw_after2", 0, 6'd0, 0, 0);
      exp_obs(0, 0, 1, 0);  cyc("rw_disp2", 1, 6'd28, 0, 0);
      exp_obs(1, 28, 1, 0); cyc("rw_exec2", 0, 6'd0, 0, 0);
      exp_obs(0, 28, 1, 0); cyc("rw_idle2", 0, 6'd0, 0, 0);

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL queue_drain: got %0d leftover, want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
